blowfish_round_engine: RTL and testbench

BLOWFISH_ROUND_ENGINE -- requirements
Module: blowfish_round_engine

---
 rtl/blowfish_round_engine.sv | 96 +++++++++
 tb/tb_blowfish_round_engine.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blowfish_round_engine.sv
// blowfish_round_engine: iterative Blowfish Feistel engine, one round every two cycles (S-box read, then update).
// Define BLOWFISH_ROUND_ENGINE_DECRYPT_EN to make the decrypt input reverse the P-array order.
module blowfish_round_engine #(
  parameter int N_ROUNDS = 16,
  parameter int P_ADDR_NBITS = 5
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic [31:0]             din,
  input  logic [P_ADDR_NBITS-1:0] P_wr_addr,
  input  logic                    P_wr_en,
  input  logic [9:0]              S_wr_addr,
  input  logic                    S_wr_en,
  input  logic [31:0]             L_in,
  input  logic [31:0]             R_in,
  input  logic                    decrypt,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             L_out,
  output logic [31:0]             R_out
);
  localparam int NP = N_ROUNDS + 2;
  typedef enum logic [2:0] {IDLE, LOAD, RD, RND, FIN} state_t;
  state_t state, state_nxt;
  logic [31:0] p [NP];
  logic [31:0] s [4][256];
  logic [31:0] s_q [4];
  logic [31:0] q [NP];
  logic [31:0] l, r, f, q_i;
  logic [4:0] i;
  logic dec, idle;
  assign idle = state == IDLE;
  assign busy = state inside {LOAD, RD, RND};
  assign done = state == FIN;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = start ? LOAD : IDLE;
      LOAD:    state_nxt = RD;
      RD:      state_nxt = RND;
      RND:     state_nxt = (int'(i) < N_ROUNDS) ? RD : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // Key material is not reset; S-box reads always follow the current L.
  always_ff @(posedge CLK) begin
    if (P_wr_en && idle)
      for (int k = 0; k < NP; k++)
        if (int'(P_wr_addr) == k) p[k] <= din;
    if (S_wr_en && idle) s[S_wr_addr[9:8]][S_wr_addr[7:0]] <= din;
    for (int b = 0; b < 4; b++) s_q[b] <= s[b][l[31-8*b -: 8]];
  end
`ifdef BLOWFISH_ROUND_ENGINE_DECRYPT_EN
  always_comb for (int k = 0; k < NP; k++) q[k] = dec ? p[NP-1-k] : p[k];
`else
  logic unused_dec;
  assign unused_dec = dec;
  always_comb for (int k = 0; k < NP; k++) q[k] = p[k];
`endif
  always_comb begin
    q_i = '0;
    for (int k = 0; k < NP; k++)
      if (int'(i) == k) q_i = q[k];
  end
  assign f = ((s_q[0] + s_q[1]) ^ s_q[2]) + s_q[3];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      i <= '0;
      l <= '0;
      r <= '0;
      L_out <= '0;
      R_out <= '0;
      dec <= 1'b0;
    end else begin
      if (idle && start) dec <= decrypt;
      if (state == LOAD) begin
        l <= L_in ^ q[0];
        r <= R_in;
        i <= 5'd1;
      end
      if (state == RND) begin
        l <= r ^ f ^ q_i;
        r <= l;
        i <= i + 5'd1;
      end
      if (state == FIN) begin
        L_out <= r ^ q[NP-1];
        R_out <= l;
      end
    end
endmodule

// File: tb/tb_blowfish_round_engine.sv
// tb_blowfish_round_engine: directed bench with a per-cycle reference model of the 16-round engine
// and literal checks on a second, 2-round instance.
module tb_blowfish_round_engine;
  localparam int N = 16;
  localparam int NP = N + 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] din = '0;
  logic [4:0] P_wr_addr = '0;
  logic P_wr_en = 1'b0;
  logic [9:0] S_wr_addr = '0;
  logic S_wr_en = 1'b0;
  logic [31:0] L_in = '0, R_in = '0;
  logic decrypt = 1'b0, start = 1'b0;
  logic busy, done, busy2, done2;
  logic [31:0] L_out, R_out, lo2, ro2;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  blowfish_round_engine #(.N_ROUNDS(16), .P_ADDR_NBITS(5)) dut (
    .CLK(clk), .RST_N(rst_n), .din(din), .P_wr_addr(P_wr_addr), .P_wr_en(P_wr_en),
    .S_wr_addr(S_wr_addr), .S_wr_en(S_wr_en), .L_in(L_in), .R_in(R_in), .decrypt(decrypt),
    .start(start), .busy(busy), .done(done), .L_out(L_out), .R_out(R_out));
  blowfish_round_engine #(.N_ROUNDS(2), .P_ADDR_NBITS(5)) dut2 (
    .CLK(clk), .RST_N(rst_n), .din(din), .P_wr_addr(P_wr_addr), .P_wr_en(P_wr_en),
    .S_wr_addr(S_wr_addr), .S_wr_en(S_wr_en), .L_in(L_in), .R_in(R_in), .decrypt(decrypt),
    .start(start), .busy(busy2), .done(done2), .L_out(lo2), .R_out(ro2));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference model: key copies, block schedule and the cipher written as a plain loop.
  logic [31:0] m_p [NP];
  logic [31:0] m_s [4][256];
  bit m_active = 1'b0, m_dec = 1'b0;
  int j = 0;
  logic [31:0] m_rl = '0, m_rr = '0, e_lout = '0, e_rout = '0;
  function automatic logic [31:0] mq(input int k);
    return m_dec ? m_p[N+1-k] : m_p[k];
  endfunction
  function automatic logic [31:0] mf(input logic [31:0] x);
    return ((m_s[0][x[31:24]] + m_s[1][x[23:16]]) ^ m_s[2][x[15:8]]) + m_s[3][x[7:0]];
  endfunction
  task automatic cipher(input logic [31:0] li, input logic [31:0] ri, output logic [31:0] lo, output logic [31:0] ro);
    logic [31:0] a, b, t;
    a = li ^ mq(0);
    b = ri;
    for (int k = 1; k <= N; k++) begin
      t = a;
      a = b ^ mf(a) ^ mq(k);
      b = t;
    end
    lo = b ^ mq(N+1);
    ro = a;
  endtask
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
      j = 0;
      m_dec = 1'b0;
      e_lout = '0;
      e_rout = '0;
    end else if (m_active) begin
      j++;
      if (j == 1) cipher(L_in, R_in, m_rl, m_rr);
      if (j == 2*N+2) begin
        m_active = 1'b0;
        e_lout = m_rl;
        e_rout = m_rr;
      end
    end else begin
      if (P_wr_en && int'(P_wr_addr) < NP) m_p[P_wr_addr] = din;
      if (S_wr_en) m_s[S_wr_addr[9:8]][S_wr_addr[7:0]] = din;
      if (start) begin
        m_active = 1'b1;
        j = 0;
`ifdef BLOWFISH_ROUND_ENGINE_DECRYPT_EN
        m_dec = decrypt;
`else
        m_dec = 1'b0;
`endif
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #2;
    if (chk_en) begin
      chk("busy", busy, m_active && j <= 2*N);
      chk("done", done, m_active && j == 2*N+1);
      chk("L_out", L_out, e_lout);
      chk("R_out", R_out, e_rout);
    end
  end
  task automatic wp(input int a, input logic [31:0] d);
    @(negedge clk);
    P_wr_en = 1'b1;
    P_wr_addr = a[4:0];
    din = d;
    @(negedge clk);
    P_wr_en = 1'b0;
  endtask
  task automatic ws(input int a, input logic [31:0] d);
    @(negedge clk);
    S_wr_en = 1'b1;
    S_wr_addr = a[9:0];
    din = d;
    @(negedge clk);
    S_wr_en = 1'b0;
  endtask
  task automatic fill_s(input bit rnd);
    for (int a = 0; a < 1024; a++) begin
      @(negedge clk);
      S_wr_en = 1'b1;
      S_wr_addr = a[9:0];
      din = rnd ? $urandom : 32'h0;
    end
    @(negedge clk);
    S_wr_en = 1'b0;
  endtask
  // One block; wr0 writes P[0]=0 alongside start, poke disturbs the engine mid-run.
  task automatic go(input logic [31:0] li, input logic [31:0] ri, input bit dec, input bit wr0,
                    input bit poke, output int dc, output int d2);
    @(negedge clk);
    L_in = li;
    R_in = ri;
    decrypt = dec;
    start = 1'b1;
    if (wr0) begin
      P_wr_en = 1'b1;
      P_wr_addr = '0;
      din = '0;
    end
    @(negedge clk);
    start = 1'b0;
    P_wr_en = 1'b0;
    dc = 1;
    d2 = 0;
    while (!done && dc < 200) begin
      if (done2 && d2 == 0) d2 = dc;
      if (poke && dc == 5) begin
        start = 1'b1;
        P_wr_en = 1'b1;
        P_wr_addr = '0;
        S_wr_en = 1'b1;
        S_wr_addr = '0;
        din = 32'hFFFFFFFF;
      end else begin
        start = 1'b0;
        P_wr_en = 1'b0;
        S_wr_en = 1'b0;
      end
      @(negedge clk);
      dc++;
    end
    chk("done_seen", done, 1);
    start = 1'b0;
    P_wr_en = 1'b0;
    S_wr_en = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int dc, d2, nd, first, second, c;
    logic [31:0] sl, sr;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_L_out", L_out, 0);
    chk("rst_R_out", R_out, 0);
    chk("rst_busy2", busy2, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    fill_s(1'b0);
    for (int a = 0; a < NP; a++) wp(a, 32'h0);
    go(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, dc, d2);
    chk("zero_lat", dc, 34);
    chk("zero_L", L_out, 32'h9ABCDEF0);
    chk("zero_R", R_out, 32'h12345678);
    chk("zero2_lat", d2, 6);
    chk("zero2_L", lo2, 32'h9ABCDEF0);
    chk("zero2_R", ro2, 32'h12345678);
    wp(0, 32'h1);
    go(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, dc, d2);
    chk("prewh_L", L_out, 32'h9ABCDEF0);
    chk("prewh_R", R_out, 32'h12345679);
    go(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1, 1'b0, dc, d2);
    chk("samecyc_R", R_out, 32'h12345678);
    @(negedge clk);
    L_in = 32'h12345678;
    R_in = 32'h9ABCDEF0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_L", L_out, 0);
    chk("abort_R", R_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    go(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b0, dc, d2);
    chk("after_abort_lat", dc, 34);
    chk("after_abort_L", L_out, 32'h9ABCDEF0);
    chk("after_abort_R", R_out, 32'h12345678);
    ws(10'h000, 32'hFFFFFFFF);
    ws(10'h100, 32'h2);
    ws(10'h300, 32'h5);
    wp(4, 32'hDEADBEEF);
    wp(18, 32'hCAFEF00D);
    wp(31, 32'h0BADF00D);
    go(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, dc, d2);
    chk("wrap_lat", d2, 6);
    chk("wrap_L", lo2, 32'h00000006);
    chk("wrap_R", ro2, 32'h00000001);
    @(negedge clk);
    L_in = 32'h13579BDF;
    R_in = 32'h2468ACE0;
    start = 1'b1;
    c = 0;
    first = 0;
    second = 0;
    while (second == 0 && c < 200) begin
      @(negedge clk);
      c++;
      if (done) begin
        if (first == 0) first = c;
        else begin
          second = c;
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first", first, 34);
    chk("b2b_gap", second - first, 35);
    repeat (10) @(negedge clk);
    go(32'hA5A5F00F, 32'h0F1E2D3C, 1'b0, 1'b0, 1'b0, dc, d2);
    sl = L_out;
    sr = R_out;
    go(32'hA5A5F00F, 32'h0F1E2D3C, 1'b0, 1'b0, 1'b1, dc, d2);
    chk("poke_L", L_out, sl);
    chk("poke_R", R_out, sr);
    repeat (10) @(negedge clk);
    go(32'hA5A5F00F, 32'h0F1E2D3C, 1'b0, 1'b0, 1'b0, dc, d2);
    chk("poke_after_L", L_out, sl);
    chk("poke_after_R", R_out, sr);
    fill_s(1'b1);
    for (int a = 0; a < NP; a++) wp(a, $urandom);
    for (int t = 0; t < 4; t++) begin
      go($urandom, $urandom, t[0], 1'b0, 1'b0, dc, d2);
      chk("rand_lat", dc, 34);
    end
`ifdef BLOWFISH_ROUND_ENGINE_DECRYPT_EN
    go(32'h01234567, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0, dc, d2);
    sl = L_out;
    sr = R_out;
    go(sl, sr, 1'b1, 1'b0, 1'b0, dc, d2);
    chk("rt_lat", dc, 34);
    chk("rt_L", L_out, 32'h01234567);
    chk("rt_R", R_out, 32'h89ABCDEF);
`endif
    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
